ex_unit_mc: RTL and testbench
=============================

# ex_unit_mc

Parametrised, multi-cycle successor of the execute stage. It combines a registered ALU, an iterative shift-add multiplier and the Z/N/C condition-code register (CCR) with pop-flags and jump-clear priority. A valid/ready handshake toward decode lets the block stall the pipeline while a multiply is in flight. It sits between the ID/EX buffer and the EX/MEM buffer, and resolves jumps for the fetch stage.

## Interface
Parameters:
- DATA_W, 16, operand/result word width; must be at least 4.
- ADDR_W, 32, PC and jump-address width; must be at least DATA_W+IMM_W.
- IMM_W, 4, width of the high immediate field (hash_imm).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous kill of the accepted/in-flight operation.
- in_valid  in  1  operation presented by ID/EX.
- in_ready  out  1  block can accept this cycle.
- op  in  4  ALU opcode (package enum).
- src_sel  in  2  ALU second-operand select: 0 rsrc_val, 1 data_imm, 2 shmt zero-extended.
- rdst_val, rsrc_val, data_imm  in  DATA_W each  operands.
- shmt  in  $clog2(DATA_W)  shift amount.
- hash_imm  in  IMM_W  high immediate for absolute jumps.
- pc  in  ADDR_W  PC of the instruction.
- set_zf, set_nf, set_cf  in  1 each  load the corresponding ALU flag at result time.
- clr_zf, clr_nf, clr_cf  in  1 each  clear the flag at acceptance.
- is_jmp  in  1  instruction is a jump.
- jmp_sel  in  2  condition: 0 always, 1 C, 2 N, 3 Z.
- jmp_src  in  1  1 absolute, 0 PC-relative.
- pop_valid  in  1  MEM stage pops flags this cycle.
- pop_flags  in  3  {Z,N,C} from memory.
- out_valid  out  1  one-cycle pulse; res_lo/res_hi valid.
- res_lo, res_hi  out  DATA_W each  result low/high word.
- flags  out  3  current CCR {Z,N,C}.
- do_jmp  out  1  registered taken-jump pulse.
- jmp_addr  out  ADDR_W  registered target.

## Operation
- Accept when in_valid & in_ready & !flush. in_ready = (state==IDLE).
- FSM states:
  - IDLE --accept MUL--> MUL.
  - MUL --(cnt==DATA_W-1)--> IDLE.
  - Any state --flush--> IDLE.
- Single-cycle ops are NOP, ADD, SUB, AND, OR, NOT, INC, DEC, SHL, SHR, PASS. Each registers its result at the accept edge.
- ADD: C is the carry out. SUB/DEC: C is the borrow.
- SHL/SHR: C is the last bit shifted out. With a shift amount of 0, C is unchanged.
- Z and N are taken from res_lo. res_hi is 0 for every op except MUL.
- MUL is unsigned, iterative, one partial product per cycle, and yields a 2·DATA_W-bit product.
  - Z = (product == 0).
  - N = product MSB.
  - C = (res_hi != 0).
- Jump resolution happens at acceptance using the current CCR.
  - taken = is_jmp & cond.
  - Absolute target = zero-extended {hash_imm, data_imm}.
  - Relative target = pc + sign-extended rdst_val, mod 2^ADDR_W.
  - A taken conditional jump clears its tested flag.
- CCR per-flag priority, highest first:
  1. reset.
  2. pop_valid, which loads pop_flags.
  3. Jump-clear.
  4. clr_x.
  5. set_x with the ALU flag at result time.
- A pop arriving during MUL applies immediately. MUL completion then applies its own latched set_x mask.

## Timing
- Reset values: in_ready=1, out_valid=0, res_lo=res_hi=0, flags=0, do_jmp=0, jmp_addr=0, state=IDLE.
- Single-cycle op accepted at edge k: out_valid/do_jmp are high in cycle k+1, and flags are updated at edge k.
- MUL accepted at edge k:
  - in_ready is low for cycles k+1..k+DATA_W.
  - Results and flags are loaded at edge k+DATA_W.
  - out_valid is high in cycle k+DATA_W+1, and in_ready is high in that same cycle, so back-to-back issue is allowed.
- For a MUL, do_jmp is always 0.
- flush during MUL: no out_valid, flags untouched except by pop, and in_ready is high the next cycle.
- Reset mid-MUL aborts immediately to the reset values.

## Structure
- Package ex_pkg: op_e enum (ADD=1 … MUL=8, POPF=11), jmp_sel constants, src_sel constants, flag index localparams.
- One sub-module, mul_iter: the shift-add datapath with counter. Its ports are start, a, b, busy, done, product. The FSM and CCR stay in the top module.

## Test plan
- ADD 0x7FFF+0x0001 with set_z/n/c → res_lo=0x8000, flags {Z,N,C}={0,1,0}, out_valid one cycle after accept.
- SUB 0x0000-0x0001 → 0xFFFF, C=1, N=1. A following JC jmp_src=0, pc=0x100, rdst=0xFFF0 → do_jmp=1, jmp_addr=0xF0, C cleared.
- MUL 0xFFFF×0xFFFF (DATA_W=16) → in_ready low 16 cycles, res_hi=0xFFFE, res_lo=0x0001, C=1, Z=0.
- pop_valid with pop_flags=3'b101 in the same cycle as clr_zf and an ALU set → flags=101 (pop wins).
- flush at cycle 5 of a MUL → no out_valid; a new ADD is accepted the next cycle and completes normally.
- reset asserted mid-MUL → all outputs 0 asynchronously. Repeat the whole suite with DATA_W=32.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: opcodes, FSM states, select encodings and CCR flag indices for ex_unit_mc
package ex_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_NOT  = 4'd5,
    OP_INC  = 4'd6,
    OP_DEC  = 4'd7,
    OP_MUL  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_POPF = 4'd11,
    OP_PASS = 4'd12
  } op_e;
  typedef enum logic {ST_IDLE, ST_MUL} state_e;
  localparam logic [1:0] JS_ALW = 2'd0, JS_C = 2'd1, JS_N = 2'd2, JS_Z = 2'd3;
  localparam logic [1:0] SRC_REG = 2'd0, SRC_IMM = 2'd1, SRC_SHMT = 2'd2;
  localparam int FZ = 2, FN = 1, FC = 0;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative unsigned shift-add multiplier, one partial product per cycle
// Ports: clk/reset, start loads a/b and (re)starts; busy while iterating; done marks
// the last iteration, during which product already holds the full 2*W-bit result.
module mul_iter #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0] mplier;
  logic [CW-1:0] cnt;
  assign done = busy & (cnt == CW'(W - 1));
  // includes the current partial product so the final step needs no extra cycle
  assign product = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc <= '0;
      mcand <= {{W{1'b0}}, a};
      mplier <= b;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + CW'(1);
      busy <= ~done;
    end
endmodule

// File: rtl/ex_unit_mc.sv
// ex_unit_mc: multi-cycle execute stage -- registered ALU, iterative MUL, Z/N/C CCR, jumps
// Ports: clk/reset; flush kills in-flight op; in_valid/in_ready handshake from ID/EX;
// op/src_sel/operands select the ALU function; set_*/clr_* drive the CCR; is_jmp/
// jmp_sel/jmp_src resolve jumps; pop_valid/pop_flags reload the CCR from MEM;
// out_valid/res_lo/res_hi carry results, flags is the CCR, do_jmp/jmp_addr go to fetch.
module ex_unit_mc
  import ex_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  op_e                       op,
  input  logic [1:0]                src_sel,
  input  logic [DATA_W-1:0]         rdst_val,
  input  logic [DATA_W-1:0]         rsrc_val,
  input  logic [DATA_W-1:0]         data_imm,
  input  logic [$clog2(DATA_W)-1:0] shmt,
  input  logic [IMM_W-1:0]          hash_imm,
  input  logic [ADDR_W-1:0]         pc,
  input  logic                      set_zf,
  input  logic                      set_nf,
  input  logic                      set_cf,
  input  logic                      clr_zf,
  input  logic                      clr_nf,
  input  logic                      clr_cf,
  input  logic                      is_jmp,
  input  logic [1:0]                jmp_sel,
  input  logic                      jmp_src,
  input  logic                      pop_valid,
  input  logic [2:0]                pop_flags,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         res_lo,
  output logic [DATA_W-1:0]         res_hi,
  output logic [2:0]                flags,
  output logic                      do_jmp,
  output logic [ADDR_W-1:0]         jmp_addr
);
  localparam int SW = $clog2(DATA_W);
  state_e state, state_n;
  logic accept, is_mul, mul_fire, taken, cv, mbusy, mdone;
  logic [DATA_W-1:0] b;
  logic [SW-1:0] s;
  logic [DATA_W:0] r, x;
  logic [2:0] set_lat, set_m, set_v, clr_m, jmask, jclr, flags_n;
  logic [2*DATA_W-1:0] prod;
  logic [ADDR_W-1:0] target;
  assign in_ready = state == ST_IDLE;
  assign accept = in_valid & in_ready & ~flush;
  assign is_mul = op == OP_MUL;
  assign mul_fire = (state == ST_MUL) & mbusy & mdone & ~flush;
  mul_iter #(.W(DATA_W)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(accept & is_mul),
    .a(rdst_val),
    .b(b),
    .busy(mbusy),
    .done(mdone),
    .product(prod)
  );
  // r[DATA_W] is the carry/borrow/shifted-out bit; cv drops when C must be left unchanged
  always_comb begin
    b = src_sel == SRC_IMM ? data_imm : src_sel == SRC_SHMT ? DATA_W'(shmt) : rsrc_val;
    s = b[SW-1:0];
    x = {rdst_val, 1'b0} >> s;
    cv = 1'b1;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, rdst_val} + {1'b0, b};
      OP_SUB:  r = {1'b0, rdst_val} - {1'b0, b};
      OP_AND:  r = {1'b0, rdst_val & b};
      OP_OR:   r = {1'b0, rdst_val | b};
      OP_NOT:  r = {1'b0, ~rdst_val};
      OP_INC:  r = {1'b0, rdst_val} + (DATA_W + 1)'(1);
      OP_DEC:  r = {1'b0, rdst_val} - (DATA_W + 1)'(1);
      OP_SHL: begin
        r = {1'b0, rdst_val} << s;
        cv = s != '0;
      end
      OP_SHR: begin
        r = {x[0], x[DATA_W:1]};
        cv = s != '0;
      end
      OP_PASS: r = {1'b0, b};
      default: r = '0;
    endcase
  end
  assign jmask = jmp_sel == JS_ALW ? 3'b000 : 3'b001 << (jmp_sel == JS_C ? FC : jmp_sel == JS_N ? FN : FZ);
  assign taken = accept & ~is_mul & is_jmp & (jmask == '0 | (|(flags & jmask)));
  assign target = jmp_src ? ADDR_W'({hash_imm, data_imm}) : pc + ADDR_W'($signed(rdst_val));
  // CCR priority: pop > jump-clear > clr_x > set_x
  assign clr_m = accept ? {clr_zf, clr_nf, clr_cf} : 3'b000;
  assign jclr = taken ? jmask : 3'b000;
  assign set_m = mul_fire ? set_lat : (accept & ~is_mul) ? {set_zf, set_nf, set_cf & cv} : 3'b000;
  assign set_v = mul_fire ? {prod == '0, prod[2*DATA_W-1], prod[2*DATA_W-1:DATA_W] != '0}
                          : {r[DATA_W-1:0] == '0, r[DATA_W-1], r[DATA_W]};
  assign flags_n = pop_valid ? pop_flags : ((flags & ~set_m) | (set_v & set_m)) & ~clr_m & ~jclr;
  assign state_n = flush ? ST_IDLE
                 : (state == ST_IDLE && accept && is_mul) ? ST_MUL
                 : (state == ST_MUL && mdone) ? ST_IDLE : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      flags <= '0;
      set_lat <= '0;
      out_valid <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
      do_jmp <= 1'b0;
      jmp_addr <= '0;
    end else begin
      state <= state_n;
      flags <= flags_n;
      out_valid <= (accept & ~is_mul) | mul_fire;
      do_jmp <= taken;
      if (taken) jmp_addr <= target;
      if (accept & is_mul) set_lat <= {set_zf, set_nf, set_cf};
      if (mul_fire) begin
        res_lo <= prod[DATA_W-1:0];
        res_hi <= prod[2*DATA_W-1:DATA_W];
      end else if (accept & ~is_mul) begin
        res_lo <= r[DATA_W-1:0];
        res_hi <= '0;
      end
    end
endmodule

// File: tb/tb_ex_unit_mc.sv
// tb_ex_unit_mc: scoreboard bench running the same suite on DATA_W=16 and DATA_W=32 instances
module tb_ex_unit_mc;
  import ex_pkg::*;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0;
  op_e op = OP_NOP;
  logic [1:0] src_sel = 0, jmp_sel = 0;
  logic [31:0] rdst = 0, rsrc = 0, imm = 0;
  logic [4:0] shmt = 0;
  logic [3:0] hash = 0;
  logic [47:0] pc = 0;
  logic set_z = 0, set_n = 0, set_c = 0, clr_z = 0, clr_n = 0, clr_c = 0;
  logic is_jmp = 0, jmp_src = 0, pop_valid = 0;
  logic [2:0] pop_flags = 0;
  int w = 16;
  logic s16;
  logic [63:0] m;
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] lo, hi;} res_t;
  res_t sb[$];
  logic o16_ready, o16_ov, o16_dj, o32_ready, o32_ov, o32_dj;
  logic [15:0] o16_lo, o16_hi;
  logic [31:0] o32_lo, o32_hi, o16_ja;
  logic [2:0] o16_fl, o32_fl;
  logic [47:0] o32_ja;
  logic v_ready, v_ov, v_dj;
  logic [31:0] v_lo, v_hi;
  logic [2:0] v_fl;
  logic [47:0] v_ja;
  assign s16 = w == 16;
  assign v_ready = s16 ? o16_ready : o32_ready;
  assign v_ov = s16 ? o16_ov : o32_ov;
  assign v_dj = s16 ? o16_dj : o32_dj;
  assign v_lo = s16 ? {16'h0, o16_lo} : o32_lo;
  assign v_hi = s16 ? {16'h0, o16_hi} : o32_hi;
  assign v_fl = s16 ? o16_fl : o32_fl;
  assign v_ja = s16 ? {16'h0, o16_ja} : o32_ja;
  always #5 clk = ~clk;
  ex_unit_mc #(.DATA_W(16), .ADDR_W(32), .IMM_W(4)) d16 (
    .clk(clk), .reset(reset), .flush(flush & s16), .in_valid(in_valid & s16), .in_ready(o16_ready),
    .op(op), .src_sel(src_sel), .rdst_val(rdst[15:0]), .rsrc_val(rsrc[15:0]), .data_imm(imm[15:0]),
    .shmt(shmt[3:0]), .hash_imm(hash), .pc(pc[31:0]), .set_zf(set_z), .set_nf(set_n), .set_cf(set_c),
    .clr_zf(clr_z), .clr_nf(clr_n), .clr_cf(clr_c), .is_jmp(is_jmp), .jmp_sel(jmp_sel), .jmp_src(jmp_src),
    .pop_valid(pop_valid & s16), .pop_flags(pop_flags), .out_valid(o16_ov), .res_lo(o16_lo), .res_hi(o16_hi),
    .flags(o16_fl), .do_jmp(o16_dj), .jmp_addr(o16_ja)
  );
  ex_unit_mc #(.DATA_W(32), .ADDR_W(48), .IMM_W(4)) d32 (
    .clk(clk), .reset(reset), .flush(flush & ~s16), .in_valid(in_valid & ~s16), .in_ready(o32_ready),
    .op(op), .src_sel(src_sel), .rdst_val(rdst), .rsrc_val(rsrc), .data_imm(imm),
    .shmt(shmt), .hash_imm(hash), .pc(pc), .set_zf(set_z), .set_nf(set_n), .set_cf(set_c),
    .clr_zf(clr_z), .clr_nf(clr_n), .clr_cf(clr_c), .is_jmp(is_jmp), .jmp_sel(jmp_sel), .jmp_src(jmp_src),
    .pop_valid(pop_valid & ~s16), .pop_flags(pop_flags), .out_valid(o32_ov), .res_lo(o32_lo), .res_hi(o32_hi),
    .flags(o32_fl), .do_jmp(o32_dj), .jmp_addr(o32_ja)
  );

  function automatic logic [2:0] mfl(input logic [63:0] p);
    return {p == 0, p[2*w-1], (p >> w) != 0};
  endfunction

  task automatic push(input logic [63:0] lo, input logic [63:0] hi);
    sb.push_back('{lo[31:0], hi[31:0]});
  endtask

  task automatic setm(input logic [2:0] sm);
    {set_z, set_n, set_c} = sm;
  endtask

  task automatic go();
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    {set_z, set_n, set_c, clr_z, clr_n, clr_c} = '0;
    is_jmp = 0;
    pop_valid = 0;
    flush = 0;
  endtask

  task automatic pop_chk(input string nm);
    res_t e;
    checks++;
    if (v_ov !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s out_valid got %b exp 1 (queue %0d)", nm, v_ov, sb.size());
    end else begin
      e = sb.pop_front();
      if (v_lo !== e.lo || v_hi !== e.hi) begin
        errors++;
        $display("FAIL %s result got %h_%h exp %h_%h", nm, v_hi, v_lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic chk_fl(input string nm, input logic [2:0] e);
    checks++;
    if (v_fl !== e) begin errors++; $display("FAIL %s_flags got %b exp %b", nm, v_fl, e); end
  endtask

  task automatic chk_rst(input string nm);
    checks++;
    if (v_ready !== 1 || v_ov !== 0 || v_dj !== 0 || v_lo !== 0 || v_hi !== 0 || v_fl !== 0 || v_ja !== 0) begin
      errors++;
      $display("FAIL %s got ready=%b ov=%b dj=%b lo=%h hi=%h fl=%b ja=%h exp 1 0 0 0 0 000 0",
               nm, v_ready, v_ov, v_dj, v_lo, v_hi, v_fl, v_ja);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    chk_rst("reset");
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_add();
    op = OP_ADD; src_sel = SRC_REG; rdst = 32'(m >> 1); rsrc = 1; setm(3'b111);
    push(64'h1 << (w - 1), 0);
    go();
    pop_chk("add");
    chk_fl("add", 3'b010);
    @(negedge clk);
    checks++;
    if (v_ov !== 0) begin errors++; $display("FAIL add_pulse out_valid got %b exp 0", v_ov); end
  endtask

  task automatic test_sub_jmp();
    logic [47:0] ea;
    op = OP_SUB; rdst = 0; rsrc = 1; setm(3'b111); push(m, 0);
    go();
    pop_chk("sub");
    chk_fl("sub", 3'b011);
    op = OP_NOP; rdst = 32'(m & ~64'hF); is_jmp = 1; jmp_sel = JS_C; jmp_src = 0; pc = 48'h100; push(0, 0);
    go();
    pop_chk("jc");
    checks++;
    if (v_dj !== 1 || v_ja !== 48'hF0) begin errors++; $display("FAIL jc got dj=%b addr=%h exp 1 f0", v_dj, v_ja); end
    chk_fl("jc", 3'b010);
    is_jmp = 1; jmp_sel = JS_Z; push(0, 0);
    go();
    pop_chk("jz_nt");
    checks++;
    if (v_dj !== 0) begin errors++; $display("FAIL jz_nt do_jmp got %b exp 0", v_dj); end
    chk_fl("jz_nt", 3'b010);
    is_jmp = 1; jmp_sel = JS_ALW; jmp_src = 1; hash = 4'hA; imm = 32'h1234; push(0, 0);
    ea = (48'hA << w) | 48'h1234;
    go();
    pop_chk("jabs");
    checks++;
    if (v_dj !== 1 || v_ja !== ea) begin errors++; $display("FAIL jabs got dj=%b addr=%h exp 1 %h", v_dj, v_ja, ea); end
    chk_fl("jabs", 3'b010);
    jmp_src = 0; hash = 0; imm = 0; rdst = 0; pc = 0;
  endtask

  task automatic test_shift();
    logic [63:0] a;
    a = (64'h1 << (w - 1)) | 64'h1;
    op = OP_SHL; src_sel = SRC_SHMT; rdst = 32'(a); shmt = 1; setm(3'b111); push(2, 0);
    go();
    pop_chk("shl1");
    chk_fl("shl1", 3'b001);
    op = OP_SHR; shmt = 0; setm(3'b111); push(a, 0);
    go();
    pop_chk("shr0");
    chk_fl("shr0", 3'b011);
    op = OP_SHR; shmt = 1; setm(3'b111); push(64'h1 << (w - 2), 0);
    go();
    pop_chk("shr1");
    chk_fl("shr1", 3'b001);
    src_sel = SRC_REG; shmt = 0;
  endtask

  task automatic test_mul(input logic [63:0] a, input logic [63:0] b, input string nm);
    logic [63:0] p;
    int bad = 0;
    p = (a & m) * (b & m);
    op = OP_MUL; rdst = 32'(a & m); rsrc = 32'(b & m); setm(3'b111); is_jmp = 1; jmp_sel = JS_ALW;
    push(p & m, p >> w);
    go();
    for (int i = 0; i < w; i++) begin
      if (v_ready !== 0 || v_ov !== 0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_busy got %0d bad cycles exp 0", nm, bad); end
    pop_chk(nm);
    checks++;
    if (v_ready !== 1 || v_dj !== 0) begin errors++; $display("FAIL %s_done got ready=%b dj=%b exp 1 0", nm, v_ready, v_dj); end
    chk_fl(nm, mfl(p));
  endtask

  task automatic test_back_to_back();
    logic [63:0] p;
    int bad = 0;
    test_mul(64'h1234, 64'h10, "b2b_first");
    p = m * m;
    op = OP_MUL; rdst = 32'(m); rsrc = 32'(m); setm(3'b111); push(p & m, p >> w);
    go();
    for (int i = 0; i < w; i++) begin
      if (v_ov !== 0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_latency got %0d early cycles exp 0", bad); end
    pop_chk("b2b_second");
    chk_fl("b2b_second", mfl(p));
  endtask

  task automatic test_pop();
    int n = 0;
    op = OP_ADD; rdst = 1; rsrc = 1; setm(3'b111); clr_z = 1; pop_valid = 1; pop_flags = 3'b101; push(2, 0);
    go();
    pop_chk("pop_add");
    chk_fl("pop_add", 3'b101);
    op = OP_MUL; rdst = 3; rsrc = 5; setm(3'b100); clr_c = 1; push(15, 0);
    go();
    chk_fl("pop_mul_clr", 3'b100);
    @(negedge clk);
    pop_valid = 1; pop_flags = 3'b111;
    @(negedge clk);
    pop_valid = 0;
    chk_fl("pop_mid_mul", 3'b111);
    while (v_ov !== 1 && n < w + 4) begin @(negedge clk); n++; end
    pop_chk("pop_mul");
    chk_fl("pop_mul_done", 3'b011);
  endtask

  task automatic test_flush();
    int bad = 0;
    op = OP_MUL; rdst = 32'(m); rsrc = 2; setm(3'b111);
    go();
    repeat (3) begin
      if (v_ov !== 0) bad++;
      @(negedge clk);
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    checks++;
    if (v_ready !== 1) begin errors++; $display("FAIL flush_ready got %b exp 1", v_ready); end
    chk_fl("flush", 3'b011);
    if (v_ov !== 0) bad++;
    op = OP_ADD; rdst = 2; rsrc = 3; setm(3'b111); push(5, 0);
    go();
    pop_chk("flush_add");
    chk_fl("flush_add", 3'b000);
    for (int i = 0; i < w + 2; i++) begin
      @(negedge clk);
      if (v_ov !== 0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flush_no_ov got %0d out_valid cycles exp 0", bad); end
  endtask

  task automatic test_reset_mid_mul();
    int bad = 0;
    op = OP_MUL; rdst = 32'(m); rsrc = 32'(m); setm(3'b111); pop_valid = 1; pop_flags = 3'b111;
    go();
    chk_fl("rst_pre", 3'b111);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1 chk_rst("rst_mid");
    @(negedge clk);
    reset = 0;
    op = OP_ADD; rdst = 1; rsrc = 2; push(3, 0);
    go();
    pop_chk("rst_recover");
    for (int i = 0; i < w + 2; i++) begin
      @(negedge clk);
      if (v_ov !== 0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_no_ov got %0d out_valid cycles exp 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      w = i == 0 ? 16 : 32;
      m = (64'h1 << w) - 1;
      test_reset();
      test_add();
      test_sub_jmp();
      test_shift();
      test_mul(m, m, "mul_max");
      test_back_to_back();
      test_pop();
      test_flush();
      test_reset_mid_mul();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got %0d entries exp 0", sb.size()); end
      sb.delete();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
